sprite_layer_scheduler: RTL and testbench

//  Per-pixel fetch scheduler and compositor for the game's sprite memories. It resolves which

---
 rtl/frogger_pkg.sv | 34 +++
 rtl/sprite_hit_calc.sv | 35 +++
 rtl/sprite_layer_scheduler.sv | 117 +++++++++++
 tb/tb_sprite_layer_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// rtl/frogger_pkg.sv - shared screen, sprite and lane constants for the frogger video path
package frogger_pkg;

  localparam int H_DISPLAY     = 640;
  localparam int V_DISPLAY     = 480;
  localparam int PLAYER_WIDTH  = 32;
  localparam int PLAYER_HEIGHT = 32;
  localparam int CAR_WIDTH     = 36;
  localparam int CAR_HEIGHT    = 32;
  localparam int NUM_CARS      = 8;

  localparam int FROG_AW = 10;
  localparam int CAR_AW  = 11;
  localparam int PIX_W   = 9;

  localparam logic [PIX_W-1:0] TRANSPARENT = 9'h000;

  // Pixel layout is {B2..B0, G2..G0, R2..R0}
  localparam int RED_LSB   = 0;
  localparam int GREEN_LSB = 3;
  localparam int BLUE_LSB  = 6;

  typedef struct packed {
    logic vis;
    logic frog_hit;
    logic car_hit;
  } stage_flags_t;

  // Three traffic lanes, cars assigned round-robin so lanes hold several cars
  function automatic logic [9:0] car_y(input int idx);
    return 10'(80 + 32 * (idx % 3));
  endfunction

endpackage

// File: rtl/sprite_hit_calc.sv
// rtl/sprite_hit_calc.sv - rectangle hit test and sprite RAM address for one object
module sprite_hit_calc #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int AW     = 10
) (
  input  logic [9:0]    h,
  input  logic [9:0]    v,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          en,
  input  logic          mirror,
  output logic          hit,
  output logic [AW-1:0] addr
);

  logic [10:0] h_ext, v_ext, x_ext, y_ext;
  logic [10:0] dx, dy, col;

  // 11-bit compares keep x+WIDTH from wrapping near the 10-bit limit
  always_comb begin
    h_ext = {1'b0, h};
    v_ext = {1'b0, v};
    x_ext = {1'b0, x};
    y_ext = {1'b0, y};
    hit   = en
            && (h_ext >= x_ext) && (h_ext < x_ext + 11'(WIDTH))
            && (v_ext >= y_ext) && (v_ext < y_ext + 11'(HEIGHT));
    dx    = h_ext - x_ext;
    dy    = v_ext - y_ext;
    col   = mirror ? (11'(WIDTH - 1) - dx) : dx;
    addr  = AW'(dy * 11'(WIDTH) + col);
  end

endmodule

// File: rtl/sprite_layer_scheduler.sv
// rtl/sprite_layer_scheduler.sv - per-pixel sprite fetch, compositing and collision detect
module sprite_layer_scheduler
  import frogger_pkg::*;
(
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [9:0]          h_count,
  input  logic [9:0]          v_count,
  input  logic [9:0]          player_x,
  input  logic [9:0]          player_y,
  input  logic [79:0]         car_x_flat,
  input  logic [7:0]          car_en,
  output logic [FROG_AW-1:0]  frog_addr,
  input  logic [PIX_W-1:0]    frog_data,
  output logic [CAR_AW-1:0]   car_addr,
  input  logic [PIX_W-1:0]    car_data,
  input  logic [PIX_W-1:0]    bg_pixel,
  output logic [PIX_W-1:0]    pixel_out,
  output logic                collision
);

  logic                frog_hit0;
  logic [FROG_AW-1:0]  frog_addr0;
  logic [NUM_CARS-1:0] car_hit0;
  logic [CAR_AW-1:0]   car_addr_arr [NUM_CARS];
  logic [CAR_AW-1:0]   car_win_addr;
  logic                any_car0;
  logic                vis0;
  logic                frame_end;
  logic                coll_set;
  logic                acc;
  logic [PIX_W-1:0]    pix_next;
  stage_flags_t        s1, s2;

  sprite_hit_calc #(
    .WIDTH (PLAYER_WIDTH),
    .HEIGHT(PLAYER_HEIGHT),
    .AW    (FROG_AW)
  ) u_frog (
    .h     (h_count),
    .v     (v_count),
    .x     (player_x),
    .y     (player_y),
    .en    (1'b1),
    .mirror(1'b0),
    .hit   (frog_hit0),
    .addr  (frog_addr0)
  );

  // Even-numbered cars drive the other way, so their artwork is read mirrored
  for (genvar i = 0; i < NUM_CARS; i++) begin : g_car
    sprite_hit_calc #(
      .WIDTH (CAR_WIDTH),
      .HEIGHT(CAR_HEIGHT),
      .AW    (CAR_AW)
    ) u_car (
      .h     (h_count),
      .v     (v_count),
      .x     (car_x_flat[10*i +: 10]),
      .y     (car_y(i)),
      .en    (car_en[i]),
      .mirror(i % 2 == 0),
      .hit   (car_hit0[i]),
      .addr  (car_addr_arr[i])
    );
  end

  // Lowest index wins the single car RAM port: scan downward so it is assigned last
  always_comb begin
    car_win_addr = '0;
    for (int i = NUM_CARS - 1; i >= 0; i--) begin
      if (car_hit0[i]) car_win_addr = car_addr_arr[i];
    end
    any_car0  = |car_hit0;
    vis0      = (h_count < 10'(H_DISPLAY)) && (v_count < 10'(V_DISPLAY));
    frame_end = (h_count == 10'd0) && (v_count == 10'(V_DISPLAY));
  end

  always_comb begin
    coll_set = s2.vis && s2.frog_hit && (frog_data != TRANSPARENT)
               && s2.car_hit && (car_data != TRANSPARENT);
    if (!s2.vis)
      pix_next = '0;
    else if (s2.frog_hit && frog_data != TRANSPARENT)
      pix_next = frog_data;
    else if (s2.car_hit && car_data != TRANSPARENT)
      pix_next = car_data;
    else
      pix_next = bg_pixel;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1        <= '0;
      s2        <= '0;
      frog_addr <= '0;
      car_addr  <= '0;
      pixel_out <= '0;
      collision <= 1'b0;
      acc       <= 1'b0;
    end else begin
      s1 <= '{vis: vis0, frog_hit: frog_hit0, car_hit: any_car0};
      s2 <= s1;
      if (frog_hit0) frog_addr <= frog_addr0;
      if (any_car0)  car_addr  <= car_win_addr;
      pixel_out <= pix_next;
      if (frame_end) begin
        collision <= acc | coll_set;
        acc       <= 1'b0;
      end else begin
        collision <= 1'b0;
        acc       <= acc | coll_set;
      end
    end
  end

endmodule

// File: tb/tb_sprite_layer_scheduler.sv
// tb/tb_sprite_layer_scheduler.sv - directed bench for the sprite layer scheduler
module tb_sprite_layer_scheduler;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [9:0]  h_count, v_count, player_x, player_y;
  logic [79:0] car_x_flat;
  logic [7:0]  car_en;
  logic [9:0]  frog_addr;
  logic [8:0]  frog_data;
  logic [10:0] car_addr;
  logic [8:0]  car_data;
  logic [8:0]  bg_pixel;
  logic [8:0]  pixel_out;
  logic        collision;

  logic [8:0] frog_mem [1024];
  logic [8:0] car_mem  [2048];

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  // Sprite RAMs with one cycle of read latency
  always @(posedge CLK) begin
    frog_data <= frog_mem[frog_addr];
    car_data  <= car_mem[car_addr];
  end

  sprite_layer_scheduler dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .h_count   (h_count),
    .v_count   (v_count),
    .player_x  (player_x),
    .player_y  (player_y),
    .car_x_flat(car_x_flat),
    .car_en    (car_en),
    .frog_addr (frog_addr),
    .frog_data (frog_data),
    .car_addr  (car_addr),
    .car_data  (car_data),
    .bg_pixel  (bg_pixel),
    .pixel_out (pixel_out),
    .collision (collision)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic park();
    h_count = 10'd700;
    v_count = 10'd10;
  endtask

  task automatic set_car(input int idx, input logic [9:0] x);
    car_x_flat[10*idx +: 10] = x;
  endtask

  task automatic test_reset();
    player_x = 10'd100; player_y = 10'd200;
    frog_mem[101] = 9'h1C0;
    h_count = 10'd105; v_count = 10'd203;
    RST_N = 1'b1;
    tick(); tick(); tick();
    tests++;
    if (pixel_out !== 9'h1C0) begin
      fails++; $display("FAIL reset_prefill pixel_out got %h want %h", pixel_out, 9'h1C0);
    end
    RST_N = 1'b0;
    tick(); tick(); tick();
    tests++;
    if ({frog_addr, car_addr, pixel_out, collision} !== 31'd0) begin
      fails++;
      $display("FAIL reset_outputs frog_addr=%h car_addr=%h pixel=%h coll=%b want all 0",
               frog_addr, car_addr, pixel_out, collision);
    end
    RST_N = 1'b1;
    tick();
    tests++;
    if (frog_addr !== 10'd101) begin
      fails++; $display("FAIL reset_addr1 frog_addr got %0d want 101", frog_addr);
    end
    tests++;
    if (pixel_out !== 9'h000) begin
      fails++; $display("FAIL reset_fill1 pixel_out got %h want 000", pixel_out);
    end
    tick();
    tests++;
    if (pixel_out !== 9'h000) begin
      fails++; $display("FAIL reset_fill2 pixel_out got %h want 000", pixel_out);
    end
    tick();
    tests++;
    if (pixel_out !== 9'h1C0) begin
      fails++; $display("FAIL reset_fill3 pixel_out got %h want 1C0", pixel_out);
    end
  endtask

  task automatic test_frog();
    player_x = 10'd100; player_y = 10'd200; car_en = 8'h00;
    h_count = 10'd100; v_count = 10'd200;
    tick();
    tests++;
    if (frog_addr !== 10'd0) begin
      fails++; $display("FAIL frog_origin frog_addr got %0d want 0", frog_addr);
    end
    h_count = 10'd105; v_count = 10'd203;
    tick();
    tests++;
    if (frog_addr !== 10'd101) begin
      fails++; $display("FAIL frog_addr frog_addr got %0d want 101", frog_addr);
    end
    park(); tick(); tick();
    tests++;
    if (pixel_out !== 9'h1C0) begin
      fails++; $display("FAIL frog_pixel pixel_out got %h want 1C0", pixel_out);
    end
    h_count = 10'd131; v_count = 10'd231;
    tick();
    tests++;
    if (frog_addr !== 10'd1023) begin
      fails++; $display("FAIL frog_corner frog_addr got %0d want 1023", frog_addr);
    end
    h_count = 10'd132; v_count = 10'd200;
    tick();
    tests++;
    if (frog_addr !== 10'd1023) begin
      fails++; $display("FAIL frog_right_edge frog_addr got %0d want 1023 (held)", frog_addr);
    end
    park(); tick(); tick();
    tests++;
    if (pixel_out !== 9'h0AA) begin
      fails++; $display("FAIL frog_edge_bg pixel_out got %h want 0AA", pixel_out);
    end
  endtask

  task automatic test_back_to_back();
    player_x = 10'd100; player_y = 10'd200; car_en = 8'h00;
    frog_mem[0] = 9'h001; frog_mem[1] = 9'h000; frog_mem[2] = 9'h004;
    v_count = 10'd200;
    h_count = 10'd100; tick();
    h_count = 10'd101; tick();
    h_count = 10'd102; tick();
    tests++;
    if (pixel_out !== 9'h001) begin
      fails++; $display("FAIL b2b_px0 pixel_out got %h want 001", pixel_out);
    end
    park(); tick();
    tests++;
    if (pixel_out !== 9'h0AA) begin
      fails++; $display("FAIL b2b_px1_transparent pixel_out got %h want 0AA", pixel_out);
    end
    tick();
    tests++;
    if (pixel_out !== 9'h004) begin
      fails++; $display("FAIL b2b_px2 pixel_out got %h want 004", pixel_out);
    end
  endtask

  task automatic test_car_mirror();
    player_x = 10'd600; player_y = 10'd400;
    car_en = 8'h01; set_car(0, 10'd50);
    car_mem[35] = 9'h007;
    h_count = 10'd50; v_count = 10'd80;
    tick();
    tests++;
    if (car_addr !== 11'd35) begin
      fails++; $display("FAIL car0_mirror car_addr got %0d want 35", car_addr);
    end
    park(); tick(); tick();
    tests++;
    if (pixel_out !== 9'h007) begin
      fails++; $display("FAIL car0_pixel pixel_out got %h want 007", pixel_out);
    end
    h_count = 10'd53; v_count = 10'd82;
    tick();
    tests++;
    if (car_addr !== 11'd104) begin
      fails++; $display("FAIL car0_offset car_addr got %0d want 104", car_addr);
    end
    car_en = 8'h02; set_car(1, 10'd50);
    car_mem[75] = 9'h038;
    h_count = 10'd50; v_count = 10'd112;
    tick();
    tests++;
    if (car_addr !== 11'd0) begin
      fails++; $display("FAIL car1_plain car_addr got %0d want 0", car_addr);
    end
    h_count = 10'd53; v_count = 10'd114;
    tick();
    tests++;
    if (car_addr !== 11'd75) begin
      fails++; $display("FAIL car1_offset car_addr got %0d want 75", car_addr);
    end
    park(); tick(); tick();
    tests++;
    if (pixel_out !== 9'h038) begin
      fails++; $display("FAIL car1_pixel pixel_out got %h want 038", pixel_out);
    end
    car_en = 8'h00;
    h_count = 10'd60; v_count = 10'd114;
    tick();
    tests++;
    if (car_addr !== 11'd75) begin
      fails++; $display("FAIL car_disabled car_addr got %0d want 75 (held)", car_addr);
    end
    park(); tick(); tick();
    tests++;
    if (pixel_out !== 9'h0AA) begin
      fails++; $display("FAIL car_disabled_pixel pixel_out got %h want 0AA", pixel_out);
    end
  endtask

  task automatic test_overlap();
    player_x = 10'd600; player_y = 10'd400;
    set_car(2, 10'd300); set_car(5, 10'd310);
    car_mem[236] = 9'h000; car_mem[221] = 9'h1FF;
    car_en = 8'h24;
    h_count = 10'd315; v_count = 10'd150;
    tick();
    tests++;
    if (car_addr !== 11'd236) begin
      fails++; $display("FAIL overlap_winner car_addr got %0d want 236", car_addr);
    end
    park(); tick(); tick();
    tests++;
    if (pixel_out !== 9'h0AA) begin
      fails++; $display("FAIL overlap_transparent pixel_out got %h want 0AA", pixel_out);
    end
    car_en = 8'h20;
    h_count = 10'd315; v_count = 10'd150;
    tick();
    tests++;
    if (car_addr !== 11'd221) begin
      fails++; $display("FAIL car5_alone car_addr got %0d want 221", car_addr);
    end
    park(); tick(); tick();
    tests++;
    if (pixel_out !== 9'h1FF) begin
      fails++; $display("FAIL car5_pixel pixel_out got %h want 1FF", pixel_out);
    end
  endtask

  task automatic test_collision();
    car_en = 8'h04; set_car(2, 10'd300);
    player_x = 10'd300; player_y = 10'd150;
    frog_mem[165] = 9'h038; car_mem[426] = 9'h007;
    h_count = 10'd305; v_count = 10'd155;
    tick();
    tests++;
    if (frog_addr !== 10'd165 || car_addr !== 11'd426) begin
      fails++; $display("FAIL coll_addrs frog=%0d car=%0d want 165/426", frog_addr, car_addr);
    end
    park(); tick(); tick();
    tests++;
    if (pixel_out !== 9'h038) begin
      fails++; $display("FAIL coll_frog_on_top pixel_out got %h want 038", pixel_out);
    end
    tick();
    tests++;
    if (collision !== 1'b0) begin
      fails++; $display("FAIL coll_mid_frame collision got %b want 0", collision);
    end
    h_count = 10'd0; v_count = 10'd480;
    tick();
    tests++;
    if (collision !== 1'b1) begin
      fails++; $display("FAIL coll_frame_end collision got %b want 1", collision);
    end
    h_count = 10'd1;
    tick();
    tests++;
    if (collision !== 1'b0) begin
      fails++; $display("FAIL coll_one_cycle collision got %b want 0", collision);
    end
    player_x = 10'd500;
    h_count = 10'd305; v_count = 10'd155;
    tick(); park(); tick(); tick();
    tests++;
    if (pixel_out !== 9'h007) begin
      fails++; $display("FAIL coll_car_only pixel_out got %h want 007", pixel_out);
    end
    h_count = 10'd0; v_count = 10'd480;
    tick();
    tests++;
    if (collision !== 1'b0) begin
      fails++; $display("FAIL coll_next_frame collision got %b want 0", collision);
    end
  endtask

  task automatic test_blanking();
    player_x = 10'd630; player_y = 10'd150;
    car_en = 8'h04; set_car(2, 10'd620);
    frog_mem[10] = 9'h1FF; car_mem[231] = 9'h1C0;
    h_count = 10'd640; v_count = 10'd150;
    tick();
    tests++;
    if (frog_addr !== 10'd10 || car_addr !== 11'd231) begin
      fails++; $display("FAIL blank_hits frog=%0d car=%0d want 10/231", frog_addr, car_addr);
    end
    park(); tick(); tick();
    tests++;
    if (pixel_out !== 9'h000) begin
      fails++; $display("FAIL blank_pixel pixel_out got %h want 000", pixel_out);
    end
    h_count = 10'd0; v_count = 10'd480;
    tick();
    tests++;
    if (collision !== 1'b0) begin
      fails++; $display("FAIL blank_no_collision collision got %b want 0", collision);
    end
  endtask

  task automatic test_wrap_bound();
    car_en = 8'h00;
    player_x = 10'd1010; player_y = 10'd20;
    h_count = 10'd1020; v_count = 10'd25;
    tick();
    tests++;
    if (frog_addr !== 10'd170) begin
      fails++; $display("FAIL wrap_bound frog_addr got %0d want 170", frog_addr);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) frog_mem[i] = 9'h000;
    for (int i = 0; i < 2048; i++) car_mem[i] = 9'h000;
    RST_N = 1'b0;
    h_count = '0; v_count = '0;
    player_x = '0; player_y = '0;
    car_x_flat = '0; car_en = '0;
    bg_pixel = 9'h0AA;
    tick(); tick();
    test_reset();
    test_frog();
    test_back_to_back();
    test_car_mirror();
    test_overlap();
    test_collision();
    test_blanking();
    test_wrap_bound();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
